// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with a refractory countdown.
// Define LIF_LEAK_EN to enable the shift-based membrane leak.
module lif_neuron #(
   parameter int REFRAC_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pre_spike,
   input  logic [7:0]          weight,
   input  logic [7:0]          threshold,
   input  logic [2:0]          leak_shift,
   input  logic [REFRAC_W-1:0] refrac_len,
   output logic                post_spike,
   output logic [7:0]          membrane,
   output logic                refractory
);

   typedef enum logic {
      S_INTEGRATE,
      S_REFRAC
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [7:0]          r_mem;
   logic [7:0]          w_mem_nxt;
   logic [REFRAC_W-1:0] r_cnt;
   logic [REFRAC_W-1:0] w_cnt_nxt;
   logic                r_post;
   logic                w_post_nxt;
   logic [7:0]          w_leaked;
   logic [7:0]          w_in;
   logic [8:0]          w_sum;
   logic [7:0]          w_sat;

`ifdef LIF_LEAK_EN
   assign w_leaked = (leak_shift == 3'd0) ? r_mem
                   : r_mem - (r_mem >> leak_shift);
`else
   logic w_unused_ls;
   assign w_unused_ls = ^leak_shift;
   assign w_leaked    = r_mem;
`endif

   assign w_in  = pre_spike ? weight : 8'd0;
   assign w_sum = {1'b0, w_leaked} + {1'b0, w_in};
   assign w_sat = w_sum[8] ? 8'hFF : w_sum[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_INTEGRATE;
         r_mem   <= 8'd0;
         r_cnt   <= '0;
         r_post  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_mem   <= w_mem_nxt;
         r_cnt   <= w_cnt_nxt;
         r_post  <= w_post_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mem_nxt   = r_mem;
      w_cnt_nxt   = r_cnt;
      w_post_nxt  = 1'b0;
      unique case (r_state)
         S_INTEGRATE: begin
            if (threshold == 8'd0) begin
               w_mem_nxt = 8'd0;
            end else if (w_sat >= threshold) begin
               w_post_nxt = 1'b1;
               w_mem_nxt  = 8'd0;
               w_cnt_nxt  = refrac_len;
               if (refrac_len != '0)
                  w_state_nxt = S_REFRAC;
            end else begin
               w_mem_nxt = w_sat;
            end
         end
         S_REFRAC: begin
            w_mem_nxt = 8'd0;
            // counter==1 is the last refractory cycle
            if (r_cnt <= 1) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_INTEGRATE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_INTEGRATE;
            w_mem_nxt   = 8'd0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign post_spike = r_post;
   assign membrane   = r_mem;
   assign refractory = (r_state == S_REFRAC);

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: arithmetic model checked every cycle
// plus literal expectations at key points.
module tb_lif_neuron;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps = 1'b0;
   logic [7:0] w = 8'd0;
   logic [7:0] thr = 8'd0;
   logic [2:0] ls = 3'd0;
   logic [3:0] rl = 4'd0;
   logic       post;
   logic [7:0] mem;
   logic       refr;

   int n_chk = 0;
   int n_fail = 0;

   int m_mem = 0;
   int m_left = 0;
   int m_post = 0;

   lif_neuron #(.REFRAC_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pre_spike (ps),
      .weight    (w),
      .threshold (thr),
      .leak_shift(ls),
      .refrac_len(rl),
      .post_spike(post),
      .membrane  (mem),
      .refractory(refr)
   );

   always #5 clk = ~clk;

   // Model: remaining refractory cycles as a plain integer
   always @(posedge clk or negedge rst_n) begin : mdl
      int lk;
      int s;
      if (!rst_n) begin
         m_mem = 0; m_left = 0; m_post = 0;
      end else if (m_left > 0) begin
         m_mem = 0; m_post = 0; m_left = m_left - 1;
      end else begin
`ifdef LIF_LEAK_EN
         lk = (ls == 0) ? m_mem : m_mem - m_mem / (1 << ls);
`else
         lk = m_mem;
`endif
         s = lk + (ps ? int'(w) : 0);
         if (s > 255) s = 255;
         if (thr != 0 && s >= int'(thr)) begin
            m_post = 1; m_mem = 0; m_left = int'(rl);
         end else begin
            m_post = 0;
            m_mem = (thr == 0) ? 0 : s;
         end
      end
   end

   always @(negedge clk) begin
      n_chk++;
      if (int'(mem) != m_mem || int'(post) != m_post
          || int'(refr) != (m_left > 0 ? 1 : 0)) begin
         n_fail++;
         $display("FAIL model t=%0t mem=%0d post=%0d refr=%0d expected mem=%0d post=%0d refr=%0d",
                  $time, mem, post, refr, m_mem, m_post, (m_left > 0));
      end
   end

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(bit p, int wt);
      ps = p;
      w = wt[7:0];
      @(posedge clk);
      #2;
   endtask

`ifdef LIF_LEAK_EN
   int exp_leak[8] = '{40, 20, 10, 5, 3, 2, 1, 1};
`else
   int exp_leak[8] = '{80, 80, 80, 80, 80, 80, 80, 80};
`endif

   initial begin
      #12;
      chk("rst_mem", mem, 0);
      chk("rst_post", post, 0);
      chk("rst_refr", refr, 0);
      rst_n = 1'b1;

      // integrate 40, 80, fire, 3 refractory cycles
      thr = 8'd100; ls = 3'd0; rl = 4'd3;
      step(1, 40); chk("int1", mem, 40);
      step(1, 40); chk("int2", mem, 80);
      step(1, 40); chk("fire_post", post, 1);
      chk("fire_mem", mem, 0); chk("fire_refr", refr, 1);
      step(0, 0); chk("ref_post", post, 0); chk("ref2", refr, 1);
      step(0, 0); chk("ref3", refr, 1);
      step(0, 0); chk("ref_end", refr, 0);

      // refractory ignores input; refrac_len change does not extend it
      step(1, 40); step(1, 40);
      step(1, 255); chk("fire2", post, 1);
      rl = 4'd7;
      step(1, 255); chk("ign_mem", mem, 0); chk("ign_post", post, 0);
      step(1, 255); chk("ign_refr", refr, 1);
      ps = 1'b0; step(0, 0); chk("len_fixed", refr, 0);

      // leak from 80
      thr = 8'd200; rl = 4'd3;
      step(1, 40); step(1, 40); chk("pre_leak", mem, 80);
      ls = 3'd1;
      for (int i = 0; i < 8; i++) begin
         step(0, 0);
         chk($sformatf("leak%0d", i), mem, exp_leak[i]);
      end

      // saturation: 200 + 200 -> 255 fires at 255
      ls = 3'd0; thr = 8'd0;
      step(0, 0); chk("thr0_clr", mem, 0);
      thr = 8'd255; rl = 4'd2;
      step(1, 200); chk("sat1", mem, 200);
      step(1, 200); chk("sat_fire", post, 1);
      step(0, 0); chk("sat_ref", refr, 1);
      step(0, 0); chk("sat_ref_end", refr, 0);

      // refrac_len 0 fires every cycle
      rl = 4'd0;
      for (int i = 0; i < 4; i++) begin
         step(1, 255);
         chk($sformatf("cont%0d", i), post, 1);
         chk($sformatf("cont_refr%0d", i), refr, 0);
      end

      // async reset mid-refractory
      thr = 8'd100; rl = 4'd3;
      step(0, 0);
      step(1, 40); step(1, 40); chk("pre_rst", mem, 80);
      step(1, 40); step(0, 0); chk("mid_ref", refr, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_mem", mem, 0); chk("arst_refr", refr, 0);
      chk("arst_post", post, 0);
      #1 rst_n = 1'b1;
      step(1, 40); chk("restart", mem, 40);

      // threshold 0 never fires
      thr = 8'd0;
      for (int i = 0; i < 20; i++) begin
         step(1, 255);
         chk("thr0_mem", mem, 0);
         chk("thr0_post", post, 0);
      end

      // mixed pattern, model-checked
      thr = 8'd250; ls = 3'd2; rl = 4'd1;
      step(1, 90); step(1, 90); step(0, 90); step(1, 90);
      step(1, 90); step(1, 90); step(0, 0); step(1, 90);
      step(1, 90); step(1, 90); step(0, 0); step(0, 0);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lif_neuron.md
LIF_NEURON -- requirements
Module: lif_neuron

Interface
REQ-001 SHALL have parameter: REFRAC_W, default 4, width of refractory-length input and counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: pre_spike  input  1  pre-synaptic spike, one-cycle pulse, sampled each rising edge.
REQ-005 SHALL have port: weight  input  8  unsigned synaptic weight, supplied by the STDP stage.
REQ-006 SHALL have port: threshold  input  8  unsigned firing threshold; 0 disables the neuron.
REQ-007 SHALL have port: leak_shift  input  3  leak divisor exponent; 0 means no leak.
REQ-008 SHALL have port: refrac_len  input  REFRAC_W  refractory length in cycles.
REQ-009 SHALL have port: post_spike  output  1  registered one-cycle output spike, drives the STDP stage's post_spike.
REQ-010 SHALL have port: membrane  output  8  current membrane potential register.
REQ-011 SHALL have port: refractory  output  1  high while the FSM is in REFRAC.

Function
REQ-012 SHALL implement FSM states INTEGRATE and REFRAC; all inputs are sampled every cycle, with no latching of configuration.
REQ-013 In INTEGRATE, each cycle SHALL compute leaked = (leak_shift==0) ? mem : mem - (mem >> leak_shift), with leak applied before input.
REQ-014 In INTEGRATE, next SHALL be sum = leaked + (pre_spike ? weight : 0), computed in 9 bits and saturated to 255.
REQ-015 If threshold != 0 and sum >= threshold: post_spike SHALL be 1 next cycle, mem <= 0, refrac counter <= refrac_len, and state <= REFRAC if refrac_len != 0, else remain in INTEGRATE.
REQ-016 Otherwise in INTEGRATE: mem <= sum, post_spike <= 0.
REQ-017 Latency SHALL be as follows: a pre_spike sampled at edge n that crosses threshold gives post_spike high for exactly the cycle following edge n.
REQ-018 In REFRAC: pre_spike SHALL be ignored, mem held at 0, post_spike 0, and the counter decrements each cycle; when counter==1 it SHALL return to INTEGRATE on that edge (exactly refrac_len cycles in REFRAC).
REQ-019 threshold==0 SHALL hold mem at 0 and never fire; if asserted during REFRAC, the refractory countdown SHALL still complete.
REQ-020 Changing refrac_len during REFRAC SHALL NOT alter the running counter.
REQ-021 post_spike SHALL NOT be asserted on two consecutive cycles when refrac_len != 0; with refrac_len==0 and sustained input, it MAY fire every cycle.

Reset
REQ-022 rst_n low SHALL asynchronously force state=INTEGRATE, mem=0, counter=0, post_spike=0, membrane=0, refractory=0.
REQ-023 Reset mid-REFRAC or mid-integration SHALL discard all accumulated state; operation resumes on the first rising edge after rst_n deasserts.

Configuration
REQ-024 Macro LIF_LEAK_EN defined: leak SHALL behave per REQ-013.
REQ-025 Macro LIF_LEAK_EN undefined: leaked = mem always, leak_shift SHALL be ignored (pure integrate-and-fire), and all other behaviour SHALL be unchanged.

Verification
REQ-026 Bench SHALL cover: threshold=100, leak_shift=0, refrac_len=3, weight=40, pre_spike on 3 consecutive cycles -> membrane 40, 80, then post_spike=1 for one cycle, membrane=0, refractory high exactly 3 cycles.
REQ-027 Bench SHALL cover: leak_shift=1, mem=80, no input, LIF_LEAK_EN defined -> membrane 40, 20, 10, 5, 3, 2, 1, 1 (1-(1>>1)=1); with LIF_LEAK_EN undefined -> membrane stays 80.
REQ-028 Bench SHALL cover: threshold=255, weight=200, two pre_spikes, leak 0 -> sum 400 saturates to 255 >= 255, so post_spike fires.
REQ-029 Bench SHALL cover: pre_spike with weight=255 during REFRAC -> membrane stays 0, no post_spike; refrac_len=0 with weight=255 every cycle -> post_spike high every cycle.
REQ-030 Bench SHALL cover: rst_n pulsed low between edges mid-REFRAC with membrane nonzero previously -> outputs zero immediately (before next edge), and integration restarts from 0.
REQ-031 Bench SHALL cover: threshold=0, weight=255, pre_spike continuous for 20 cycles -> membrane 0, post_spike never asserted.
